console_rx_slave: RTL and testbench
===================================

Name: console_rx_slave

Overview:
- Memory-mapped console input device: the CPU-to-host direction of the console channel, reversed.
- Bytes pushed by the testbench/host are buffered in a FIFO. The CPU reads them over a single-master, read-only AXI 128-bit slave channel at the console window (BASE_ADDR).
- Sits beside the 128-bit AXI memory slave in the SoC. The upstream address decoder routes only console-window reads here. The write channel is out of scope and stays with the existing console-output path.

Parameters:
- BASE_ADDR, 40'h01ff_fff0, 16-byte aligned console window base; only araddr[3:2] is decoded.
- FIFO_DEPTH, 16, RX byte FIFO entries; power of 2, at least 2.
- ID_W, 8, AXI ID width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- host_rx_valid  in  1  one-cycle push strobe from host; no backpressure.
- host_rx_data  in  8  byte to push.
- arvalid  in  1  AXI read address valid.
- arready  out  1  AXI read address ready.
- araddr  in  40  read address; bits [3:2] select the register.
- arlen  in  4  burst length minus 1.
- arid  in  ID_W  read ID.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rdata  out  128  read data.
- rresp  out  2  00 OKAY, 10 SLVERR.
- rlast  out  1  last beat.
- rid  out  ID_W  echoed arid.
- rx_irq  out  1  level interrupt: FIFO not empty.

Behaviour:
- Reset: all outputs 0 except arready=1. FIFO empty, overflow flag 0, drop count 0, FSM in IDLE. Reset mid-transaction abandons the beat without popping.
- Register map, by 32-bit lane araddr[3:2]:
  - 0 RXDATA: [7:0] byte, [8] valid, rest 0.
  - 1 STATUS: [0] not_empty, [1] overflow, [15:8] fifo count, rest 0.
  - 2 DROPCNT: [7:0] saturating drop count.
  - 3 reads 0.
  - The selected 32-bit value goes in rdata lane araddr[3:2]; other lanes are 0.
- FSM IDLE -> RESP -> IDLE:
  - IDLE: arready=1. On arvalid&&arready, latch id, len, lane. Snapshot the register value into rdata (FIFO head for RXDATA). Go to RESP. arready drops the next cycle.
  - RESP: rvalid=1; rdata, rresp, rid and rlast hold steady until rready. On rvalid&&rready: if the beat counter equals len, go to IDLE with arready=1 the next cycle; otherwise increment the counter.
  - Minimum latency is AR handshake to rvalid in 1 cycle. Back-to-back throughput is one read every 2 cycles.
- Bursts: arlen!=0 returns arlen+1 beats, all with rdata=0 and rresp=SLVERR; rlast only on the final beat; no side effects.
- Pop: exactly one FIFO pop on the R handshake of a single-beat RXDATA read whose snapshot had valid=1. An empty snapshot returns valid=0 and does not pop.
- STATUS read side effect: clears the overflow flag on its R handshake. If a drop occurs in the same cycle, overflow stays 1 (set wins).
- Push: host_rx_valid with FIFO not full writes the byte.
  - If full, the byte is dropped, overflow is set and DROPCNT increments, saturating at 255.
  - Push and pop in the same cycle when full: the push is evaluated against pre-pop fullness, so it is dropped.
  - Push and pop in the same cycle when not full: both occur and the count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- rx_irq is registered and follows not_empty with 1 cycle of lag.

Decomposition:
- Shared package console_pkg holds:
  - Register offsets: RXDATA=0, STATUS=1, DROPCNT=2.
  - AXI response codes RESP_OKAY and RESP_SLVERR.
  - FSM state enum {IDLE, RESP}.
  - Bit positions RX_VALID_BIT=8, ST_OVF_BIT=1.
- One natural sub-module: console_rx_fifo, a synchronous byte FIFO with push, pop, full, empty and count outputs.

Test Plan:
- Reset, then push 0x41 and 0x42, then read RXDATA (araddr=BASE, arlen=0) -> rdata[31:0]=0x141 OKAY rlast=1, then 0x142, then 0x000 with no pop; rx_irq falls 1 cycle after the second pop.
- Push 17 bytes 0x00..0x10 with FIFO_DEPTH=16 -> byte 0x10 dropped; STATUS (araddr=BASE+4) rdata[63:32]=0x1003 in lane 1; DROPCNT=1; a second STATUS read shows overflow=0.
- Hold rready=0 for 5 cycles during an RXDATA beat with a push arriving meanwhile -> rdata stable, single pop only on the handshake, count ends unchanged.
- Burst read with arlen=3, id=0x5A -> 4 beats, rdata=0, rresp=2'b10, rid=0x5A, rlast only on beat 4, FIFO untouched.
- Full FIFO, simultaneous host push and RXDATA pop handshake -> push dropped, DROPCNT increments, count becomes 15.
- Assert rst while in RESP with an RXDATA beat pending -> next cycle rvalid=0, arready=1, FIFO empty, DROPCNT=0.

Source files
------------

// File: rtl/console_pkg.sv
// Shared definitions for the console receive path: register lanes, AXI
// response codes, slave FSM states and register bit positions.
package console_pkg;

  localparam logic [1:0] REG_RXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DROPCNT = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int RX_VALID_BIT = 8;
  localparam int ST_OVF_BIT   = 1;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

endpackage

// File: rtl/console_rx_fifo.sv
// Synchronous byte FIFO. A push is judged against the fullness before any
// same-cycle pop, so a push into a full FIFO is refused even while popping.
module console_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/console_rx_slave.sv
// Console input device: host bytes are queued in a FIFO and read by the CPU
// through a read-only 128-bit AXI slave (RXDATA / STATUS / DROPCNT lanes).
module console_rx_slave
  import console_pkg::*;
#(
  parameter logic [39:0] BASE_ADDR  = 40'h01ff_fff0,
  parameter int          FIFO_DEPTH = 16,
  parameter int          ID_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            host_rx_valid,
  input  logic [7:0]      host_rx_data,
  input  logic            arvalid,
  output logic            arready,
  input  logic [39:0]     araddr,
  input  logic [3:0]      arlen,
  input  logic [ID_W-1:0] arid,
  output logic            rvalid,
  input  logic            rready,
  output logic [127:0]    rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic [ID_W-1:0] rid,
  output logic            rx_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  state_t          next_state;
  logic [ID_W-1:0] id_q;
  logic [3:0]      len_q;
  logic [3:0]      beat_q;
  logic [127:0]    rdata_q;
  logic [1:0]      rresp_q;
  logic            pop_pend;
  logic            clr_pend;
  logic            ovf;
  logic [7:0]      drop_cnt;
  logic            irq_q;

  logic [7:0]      head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;

  logic            ar_hs;
  logic            r_hs;
  logic            last_beat;
  logic            drop;
  logic            fifo_pop;
  logic [1:0]      lane;
  logic [31:0]     reg_val;
  logic [127:0]    snap;
  logic            unused_bits;

  // The upstream decoder already selects the window; only the lane bits matter.
  assign unused_bits = ^{araddr[39:4], araddr[1:0], BASE_ADDR};

  assign lane      = araddr[3:2];
  assign ar_hs     = arvalid && arready;
  assign r_hs      = rvalid && rready;
  assign last_beat = (beat_q == len_q);
  assign drop      = host_rx_valid && full;
  assign fifo_pop  = r_hs && pop_pend;

  console_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (host_rx_valid),
    .push_data (host_rx_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    reg_val = '0;
    case (lane)
      REG_RXDATA: begin
        if (!empty) begin
          reg_val[7:0]         = head;
          reg_val[RX_VALID_BIT] = 1'b1;
        end
      end
      REG_STATUS: begin
        reg_val[0]          = !empty;
        reg_val[ST_OVF_BIT] = ovf;
        reg_val[15:8]       = 8'(count);
      end
      REG_DROPCNT: reg_val[7:0] = drop_cnt;
      default:     reg_val = '0;
    endcase
  end

  // Bursts are unsupported: every beat carries zero data.
  assign snap = (arlen == 4'd0) ? ({96'b0, reg_val} << {lane, 5'b0}) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (state)
      IDLE: begin
        arready = 1'b1;
        if (arvalid) next_state = RESP;
      end
      RESP: begin
        rvalid = 1'b1;
        if (rready && last_beat) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      pop_pend <= 1'b0;
      clr_pend <= 1'b0;
    end else if (ar_hs) begin
      id_q     <= arid;
      len_q    <= arlen;
      beat_q   <= '0;
      rdata_q  <= snap;
      rresp_q  <= (arlen == 4'd0) ? RESP_OKAY : RESP_SLVERR;
      pop_pend <= (arlen == 4'd0) && (lane == REG_RXDATA) && !empty;
      clr_pend <= (arlen == 4'd0) && (lane == REG_STATUS);
    end else if (r_hs && !last_beat) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  // A drop in the same cycle as a STATUS read keeps the overflow flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= !empty;
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
      end else if (r_hs && clr_pend) begin
        ovf <= 1'b0;
      end
    end
  end

  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rid    = id_q;
  assign rlast  = rvalid && last_beat;
  assign rx_irq = irq_q;

endmodule

// File: tb/tb_console_rx_slave.sv
// Self-checking bench for console_rx_slave: directed vector table, random
// traffic against a queue-based model, and hand-written reset/corner sequences.
module tb_console_rx_slave;

  localparam logic [39:0] BASE = 40'h01ff_fff0;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         host_rx_valid;
  logic [7:0]   host_rx_data;
  logic         arvalid;
  logic         arready;
  logic [39:0]  araddr;
  logic [3:0]   arlen;
  logic [7:0]   arid;
  logic         rvalid;
  logic         rready;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic [7:0]   rid;
  logic         rx_irq;

  console_rx_slave #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .ID_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .host_rx_valid (host_rx_valid),
    .host_rx_data  (host_rx_data),
    .arvalid       (arvalid),
    .arready       (arready),
    .araddr        (araddr),
    .arlen         (arlen),
    .arid          (arid),
    .rvalid        (rvalid),
    .rready        (rready),
    .rdata         (rdata),
    .rresp         (rresp),
    .rlast         (rlast),
    .rid           (rid),
    .rx_irq        (rx_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: byte queue, overflow flag, saturating drop count.
  byte unsigned mq[$];
  bit           m_ovf;
  int           m_drop;

  typedef struct {
    bit          is_read;
    logic [7:0]  data;
    int          n;
    logic [1:0]  lane;
    logic [3:0]  len;
    logic [7:0]  id;
    int          stall;
    int          push_cyc;
    logic [7:0]  push_val;
    logic [31:0] exp_val;
    logic [1:0]  exp_resp;
    bit          irq_fall;
    string       tag;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (mq.size() >= DEPTH) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end else begin
      mq.push_back(b);
    end
  endtask

  function automatic logic [31:0] model_val(input logic [1:0] lane, input logic [3:0] len);
    logic [31:0] v;
    v = 32'h0;
    if (len == 4'd0) begin
      case (lane)
        2'd0: if (mq.size() != 0) v = 32'h100 + 32'(mq[0]);
        2'd1: v = (32'(mq.size()) * 256) + (m_ovf ? 32'd2 : 32'd0) + ((mq.size() != 0) ? 32'd1 : 32'd0);
        2'd2: v = 32'(m_drop);
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    host_rx_valid = 1'b1;
    host_rx_data  = b;
    tick();
    host_rx_valid = 1'b0;
    model_push(b);
  endtask

  // push_cyc: cycle index within the final beat's wait (stall == handshake cycle).
  task automatic axi_read(input logic [1:0] lane, input logic [3:0] len, input logic [7:0] id,
                          input int stall, input int push_cyc, input logic [7:0] push_val,
                          input logic [31:0] exp_val, input logic [1:0] exp_resp, input string tag);
    logic [127:0] exp_data;
    int guard;
    int st;
    bit snap_nonempty;
    bit pushed;
    bit hs;
    exp_data = (len == 4'd0) ? ({96'b0, exp_val} << (32 * int'(lane))) : 128'h0;
    arvalid = 1'b1;
    araddr  = BASE + {36'b0, lane, 2'b00};
    arlen   = len;
    arid    = id;
    guard   = 0;
    while (!arready && guard < 20) begin
      tick();
      guard++;
    end
    if (!arready) begin
      checks++;
      failures++;
      $display("FAIL %s_arready_timeout: got 0 expected 1", tag);
      arvalid = 1'b0;
      return;
    end
    snap_nonempty = (mq.size() != 0);
    tick();
    arvalid = 1'b0;
    chk({tag, "_arready_low"}, 128'(arready), 128'(0));
    for (int b = 0; b <= int'(len); b++) begin
      st = (b == int'(len)) ? stall : 0;
      for (int k = 0; k <= st; k++) begin
        pushed = (b == int'(len)) && (k == push_cyc);
        hs = (k == st);
        if (pushed) begin
          host_rx_valid = 1'b1;
          host_rx_data  = push_val;
        end
        rready = hs;
        chk({tag, "_rvalid"}, 128'(rvalid), 128'(1));
        chk({tag, "_rdata"}, rdata, exp_data);
        chk({tag, "_rresp"}, 128'(rresp), 128'(exp_resp));
        chk({tag, "_rid"}, 128'(rid), 128'(id));
        chk({tag, "_rlast"}, 128'(rlast), 128'(b == int'(len)));
        tick();
        host_rx_valid = 1'b0;
        if (hs && b == int'(len) && len == 4'd0 && lane == 2'd1) m_ovf = 1'b0;
        if (pushed) model_push(push_val);
        if (hs && b == int'(len) && len == 4'd0 && lane == 2'd0 && snap_nonempty) void'(mq.pop_front());
      end
      rready = 1'b0;
    end
    chk({tag, "_rvalid_end"}, 128'(rvalid), 128'(0));
    chk({tag, "_arready_end"}, 128'(arready), 128'(1));
  endtask

  function automatic vec_t mk_push(input logic [7:0] data, input int n);
    vec_t v;
    v = '{default: '0, tag: "push"};
    v.is_read = 1'b0;
    v.data = data;
    v.n = n;
    v.push_cyc = -1;
    return v;
  endfunction

  function automatic vec_t mk_read(input logic [1:0] lane, input logic [3:0] len, input logic [7:0] id,
                                   input int stall, input int push_cyc, input logic [7:0] push_val,
                                   input logic [31:0] exp_val, input logic [1:0] exp_resp,
                                   input bit irq_fall, input string tag);
    vec_t v;
    v = '{default: '0, tag: tag};
    v.is_read = 1'b1;
    v.lane = lane;
    v.len = len;
    v.id = id;
    v.stall = stall;
    v.push_cyc = push_cyc;
    v.push_val = push_val;
    v.exp_val = exp_val;
    v.exp_resp = exp_resp;
    v.irq_fall = irq_fall;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    host_rx_valid = 1'b0;
    host_rx_data = 8'h0;
    arvalid = 1'b0;
    araddr = BASE;
    arlen = 4'd0;
    arid = 8'h0;
    rready = 1'b0;
    m_ovf = 1'b0;
    m_drop = 0;

    tick();
    tick();
    chk("rst_arready", 128'(arready), 128'(1));
    chk("rst_rvalid", 128'(rvalid), 128'(0));
    chk("rst_rdata", rdata, 128'h0);
    chk("rst_rlast", 128'(rlast), 128'(0));
    chk("rst_rresp", 128'(rresp), 128'(0));
    chk("rst_rid", 128'(rid), 128'(0));
    chk("rst_irq", 128'(rx_irq), 128'(0));
    rst = 1'b0;
    tick();

    tbl.push_back(mk_push(8'h41, 1));
    tbl.push_back(mk_push(8'h42, 1));
    tbl.push_back(mk_read(2'd0, 4'd0, 8'h01, 0, -1, 8'h00, 32'h141, 2'b00, 1'b0, "rx_first"));
    tbl.push_back(mk_read(2'd0, 4'd0, 8'h02, 0, -1, 8'h00, 32'h142, 2'b00, 1'b1, "rx_second"));
    tbl.push_back(mk_read(2'd0, 4'd0, 8'h03, 0, -1, 8'h00, 32'h000, 2'b00, 1'b0, "rx_empty"));
    tbl.push_back(mk_push(8'h00, 17));
    tbl.push_back(mk_read(2'd1, 4'd0, 8'h04, 0, -1, 8'h00, 32'h1003, 2'b00, 1'b0, "status_ovf"));
    tbl.push_back(mk_read(2'd2, 4'd0, 8'h05, 0, -1, 8'h00, 32'h1, 2'b00, 1'b0, "dropcnt1"));
    tbl.push_back(mk_read(2'd1, 4'd0, 8'h06, 0, -1, 8'h00, 32'h1001, 2'b00, 1'b0, "status_clr"));
    tbl.push_back(mk_read(2'd0, 4'd3, 8'h5A, 0, -1, 8'h00, 32'h0, 2'b10, 1'b0, "burst"));
    tbl.push_back(mk_read(2'd1, 4'd0, 8'h07, 0, -1, 8'h00, 32'h1001, 2'b00, 1'b0, "status_post_burst"));
    tbl.push_back(mk_read(2'd0, 4'd0, 8'h08, 0, 0, 8'h99, 32'h100, 2'b00, 1'b0, "full_pushpop"));
    tbl.push_back(mk_read(2'd2, 4'd0, 8'h09, 0, -1, 8'h00, 32'h2, 2'b00, 1'b0, "dropcnt2"));
    tbl.push_back(mk_read(2'd0, 4'd0, 8'h0A, 5, 2, 8'h77, 32'h101, 2'b00, 1'b0, "stall_rx"));
    tbl.push_back(mk_read(2'd1, 4'd0, 8'h0B, 0, -1, 8'h00, 32'h0F03, 2'b00, 1'b0, "status_15"));
    tbl.push_back(mk_read(2'd3, 4'd0, 8'h0C, 0, -1, 8'h00, 32'h0, 2'b00, 1'b0, "lane3"));
    tbl.push_back(mk_read(2'd1, 4'd0, 8'h0D, 1, -1, 8'h00, 32'h0F01, 2'b00, 1'b0, "status_15_clr"));

    foreach (tbl[i]) begin
      if (!tbl[i].is_read) begin
        for (int j = 0; j < tbl[i].n; j++) push_byte(tbl[i].data + 8'(j));
      end else begin
        axi_read(tbl[i].lane, tbl[i].len, tbl[i].id, tbl[i].stall, tbl[i].push_cyc,
                 tbl[i].push_val, tbl[i].exp_val, tbl[i].exp_resp, tbl[i].tag);
        if (tbl[i].irq_fall) begin
          chk({tbl[i].tag, "_irq_lag"}, 128'(rx_irq), 128'(1));
          tick();
          chk({tbl[i].tag, "_irq_fall"}, 128'(rx_irq), 128'(0));
        end
      end
    end
    tick();
    chk("tbl_irq", 128'(rx_irq), 128'(mq.size() != 0));

    for (int it = 0; it < 250; it++) begin
      int r;
      logic [1:0] lane;
      logic [3:0] len;
      int stall;
      int pc;
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        push_byte(8'($urandom));
      end else begin
        lane  = 2'($urandom_range(0, 3));
        len   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 5)) : 4'd0;
        stall = int'($urandom_range(0, 3));
        pc    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, stall)) : -1;
        axi_read(lane, len, 8'($urandom), stall, pc, 8'($urandom),
                 model_val(lane, len), (len == 4'd0) ? 2'b00 : 2'b10, "rand");
      end
      tick();
      chk("rand_irq", 128'(rx_irq), 128'(mq.size() != 0));
    end

    push_byte(8'h33);
    arvalid = 1'b1;
    araddr  = BASE;
    arlen   = 4'd0;
    arid    = 8'h11;
    tick();
    arvalid = 1'b0;
    chk("midrst_pre_rvalid", 128'(rvalid), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_drop = 0;
    chk("midrst_rvalid", 128'(rvalid), 128'(0));
    chk("midrst_arready", 128'(arready), 128'(1));
    chk("midrst_irq", 128'(rx_irq), 128'(0));
    axi_read(2'd1, 4'd0, 8'h21, 0, -1, 8'h00, 32'h0, 2'b00, "midrst_status");
    axi_read(2'd2, 4'd0, 8'h22, 0, -1, 8'h00, 32'h0, 2'b00, "midrst_dropcnt");
    axi_read(2'd0, 4'd0, 8'h23, 0, -1, 8'h00, 32'h0, 2'b00, "midrst_rxdata");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
